// File: rtl/i2s_state.sv
// i2s_state: self-contained I2S transmitter that streams an internal square-wave
// test tone as a stereo 16-bit stream (32-slot frame: 16 left + 16 right).
//
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous, active-high reset
//   lrclk    out word select (0 = left, 1 = right)
//   i2s_sclk out serial bit clock (SCLK_HALF clk cycles per half period)
//   i2s_data out serial data, MSB first, one-bit I2S delay after lrclk change
//
// Also contains square_wave_gen, the tone source.
//
// square_wave_gen ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   sq_wave  out square wave toggling every CLK_FREQ/(2*OUT_FREQ) cycles

module square_wave_gen #(
  parameter int CLK_FREQ = 1_000_000,
  parameter int OUT_FREQ = 50_000
) (
  input  logic clk,
  input  logic reset,
  output logic sq_wave
);

  localparam int HALF = CLK_FREQ / (2 * OUT_FREQ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          sq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_q <= '0;
      sq_q  <= ~sq_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sq_wave = sq_q;

endmodule

// state | meaning
// IDLE  | after reset, waiting for the first sclk falling edge
// LEFT  | slots 1..15 (and slot 0), lrclk low
// RIGHT | slots 16..31, lrclk high
module i2s_state #(
  parameter int          CLK_FREQ  = 1_000_000,
  parameter int          TONE_FREQ = 1_000,
  parameter int          SCLK_HALF = 4,
  parameter logic [15:0] AMPLITUDE = 16'h4000
) (
  input  logic clk,
  input  logic reset,
  output logic lrclk,
  output logic i2s_sclk,
  output logic i2s_data
);

  localparam int DW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_cnt_q;
  logic          sclk_q;
  logic [4:0]    slot_cnt_q;
  logic [4:0]    slot_cnt_d;
  logic [31:0]   shift_q;
  logic          lrclk_q;
  logic          sq_wave;
  logic          div_wrap;
  logic          fall_evt;
  logic [15:0]   sample;

  square_wave_gen #(
    .CLK_FREQ(CLK_FREQ),
    .OUT_FREQ(TONE_FREQ)
  ) u_tone (
    .clk    (clk),
    .reset  (reset),
    .sq_wave(sq_wave)
  );

  always_comb begin
    div_wrap   = (div_cnt_q == DW'(SCLK_HALF - 1));
    // The cycle on which sclk is registered going 1 -> 0.
    fall_evt   = div_wrap && sclk_q;
    slot_cnt_d = slot_cnt_q + 5'd1;
    sample     = sq_wave ? AMPLITUDE : 16'(~AMPLITUDE + 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      slot_cnt_q <= '0;
      shift_q    <= '0;
      lrclk_q    <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt_q <= '0;
        sclk_q    <= ~sclk_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end

      if (fall_evt) begin
        slot_cnt_q <= slot_cnt_d;

        case (state_q)
          IDLE: begin
            state_q <= LEFT;
            lrclk_q <= 1'b0;
          end
          LEFT: begin
            if (slot_cnt_d == 5'd16) begin
              state_q <= RIGHT;
              lrclk_q <= 1'b1;
            end
          end
          RIGHT: begin
            if (slot_cnt_d == 5'd0) begin
              state_q <= LEFT;
              lrclk_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            lrclk_q <= 1'b0;
          end
        endcase

        // Load lands in slot 1 so the MSB trails lrclk by one bit; the right
        // LSB therefore falls in slot 0 of the next frame.
        if (slot_cnt_d == 5'd1) begin
          shift_q <= {sample, sample};
        end else begin
          shift_q <= {shift_q[30:0], 1'b0};
        end
      end
    end
  end

  assign lrclk    = lrclk_q;
  assign i2s_sclk = sclk_q;
  // Data is the shift register MSB, so it only moves on falling-edge events.
  assign i2s_data = shift_q[31];

endmodule

// File: tb/tb_i2s_state.sv
module tb_i2s_state;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic lrclk;
  logic i2s_sclk;
  logic i2s_data;
  logic sq_ref;

  int total = 0;
  int bad   = 0;

  logic [15:0] left_w[$];
  logic [15:0] right_w[$];

  always #5 clk = ~clk;

  i2s_state dut (
    .clk     (clk),
    .reset   (reset),
    .lrclk   (lrclk),
    .i2s_sclk(i2s_sclk),
    .i2s_data(i2s_data)
  );

  square_wave_gen #(
    .CLK_FREQ(1_000_000),
    .OUT_FREQ(50_000)
  ) u_sq (
    .clk    (clk),
    .reset  (reset),
    .sq_wave(sq_ref)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word of frame k at defaults: load edge is 8*(1+32k) after
  // release; the tone toggles every 500 edges.
  function automatic logic [15:0] exp_word(input int k);
    int t;
    t = 8 * (1 + 32 * k);
    return (((t - 1) / 500) % 2 == 1) ? 16'h4000 : 16'hC000;
  endfunction

  function automatic logic exp_lr(input int n);
    int m;
    m = n / 8;
    if (m == 0) return 1'b0;
    return ((m % 32) >= 16);
  endfunction

  function automatic logic exp_data(input int n);
    int m, s, mload, b;
    logic [15:0] w;
    m = n / 8;
    if (m == 0) return 1'b0;
    s = m % 32;
    mload = (s == 0) ? m - 31 : m - (s - 1);
    b = (s == 0) ? 0 : 32 - s;
    w = (((8 * mload - 1) / 500) % 2 == 1) ? 16'h4000 : 16'hC000;
    return w[b % 16];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sclk"}, i2s_sclk, 0);
    chk({tag, "_lrclk"}, lrclk, 0);
    chk({tag, "_data"}, i2s_data, 0);
    chk({tag, "_sq"}, sq_ref, 0);
  endtask

  // n counts clk edges since reset release; outputs sampled 1 time unit later.
  task automatic run_after_release(input int ncyc);
    logic [15:0] dec;
    int first_rise, first_lr_rise, first_lr_fall, m;
    logic prev_lr;
    dec = '0;
    first_rise = -1;
    first_lr_rise = -1;
    first_lr_fall = -1;
    prev_lr = 1'b0;
    left_w.delete();
    right_w.delete();
    for (int n = 1; n <= ncyc; n++) begin
      step();
      chk("sclk", i2s_sclk, (n / 4) % 2);
      chk("lrclk", lrclk, exp_lr(n));
      chk("data", i2s_data, exp_data(n));
      chk("sq_ref", sq_ref, (n / 10) % 2);
      if (first_rise < 0 && i2s_sclk === 1'b1) first_rise = n;
      if (first_lr_rise < 0 && lrclk === 1'b1 && !prev_lr) first_lr_rise = n;
      if (first_lr_fall < 0 && lrclk === 1'b0 && prev_lr) first_lr_fall = n;
      prev_lr = (lrclk === 1'b1);
      m = n / 8;
      if (n % 8 == 4 && m >= 1) begin
        dec = {dec[14:0], i2s_data};
        if (m % 32 == 16) left_w.push_back(dec);
        if (m % 32 == 0) right_w.push_back(dec);
      end
    end
    chk("first_sclk_rise", first_rise, 4);
    if (ncyc >= 300) begin
      chk("first_lrclk_rise", first_lr_rise, 128);
      chk("first_lrclk_fall", first_lr_fall, 256);
    end
  endtask

  task automatic check_words(input int min_frames);
    chk("left_count_ok", (left_w.size() >= min_frames), 1);
    foreach (left_w[k]) chk($sformatf("left_word%0d", k), left_w[k], exp_word(k));
    foreach (right_w[k]) chk($sformatf("right_word%0d", k), right_w[k], exp_word(k));
  endtask

  initial begin
    // Power-up reset.
    for (int i = 0; i < 4; i++) begin
      step();
      check_reset_outputs("por");
    end
    reset = 1'b0;

    // About 3 ms at defaults.
    run_after_release(3000);
    check_words(5);
    if (left_w.size() >= 5) begin
      chk("frame0_left", left_w[0], 16'hC000);
      chk("frame2_left", left_w[2], 16'h4000);
      chk("frame4_left", left_w[4], 16'hC000);
    end
    if (right_w.size() >= 1) chk("frame0_right", right_w[0], 16'hC000);

    // Fresh start, then a 3-cycle reset in slot 20.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("rst2");
    reset = 1'b0;
    run_after_release(164);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs("midrst");
    end
    reset = 1'b0;
    run_after_release(700);
    check_words(3);
    if (left_w.size() >= 3) chk("after_midrst_left2", left_w[2], 16'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
